// File: rtl/ch_msg_decoder_pkg.sv
// Shared constants and types for the IFM/PBM message decoder: ASCII bytes,
// unit codes, parser states and the digit-to-node map.
package ch_msg_decoder_pkg;

    localparam logic [7:0] ChI    = 8'h49;
    localparam logic [7:0] ChF    = 8'h46;
    localparam logic [7:0] ChM    = 8'h4D;
    localparam logic [7:0] ChP    = 8'h50;
    localparam logic [7:0] ChB    = 8'h42;
    localparam logic [7:0] ChS    = 8'h53;
    localparam logic [7:0] ChU    = 8'h55;
    localparam logic [7:0] ChE    = 8'h45;
    localparam logic [7:0] ChC    = 8'h43;
    localparam logic [7:0] ChR    = 8'h52;
    localparam logic [7:0] ChDash = 8'h2D;
    localparam logic [7:0] ChHash = 8'h23;

    typedef enum logic [1:0] {
        UnitEmpty = 2'd0,
        UnitE     = 2'd1,
        UnitC     = 2'd2,
        UnitR     = 2'd3
    } unit_code_e;

    typedef enum logic [4:0] {
        StIdle,
        StIfmHdr0, StIfmHdr1, StIfmHdr2, StIfmHdr3,
        StIfmUnit,
        StIfmTail0, StIfmTail1, StIfmTail2,
        StPbmHdr0, StPbmHdr1, StPbmHdr2, StPbmHdr3,
        StPbmBody0, StPbmBody1, StPbmBody2, StPbmBody3, StPbmBody4,
        StPbmTail0, StPbmTail1
    } state_e;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        return b;
    endfunction

    function automatic unit_code_e letter_to_unit(input logic [7:0] b);
        case (b)
            ChE:     return UnitE;
            ChC:     return UnitC;
            ChR:     return UnitR;
            default: return UnitEmpty;
        endcase
    endfunction

    function automatic logic [5:0] digit_to_node(input logic [7:0] d);
        case (d)
            8'h31:   return 6'd22;
            8'h32:   return 6'd10;
            8'h33:   return 6'd23;
            8'h34:   return 6'd11;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/ch_msg_decoder_unit_table.sv
// Unit-code register file: one synchronous write port, one combinational read port.
module unit_table
    import ch_msg_decoder_pkg::*;
#(
    parameter int unsigned MAX_UNITS = 4,
    parameter int unsigned CODE_W    = 2,
    parameter int unsigned IDX_W     = $clog2(MAX_UNITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] mem_q [MAX_UNITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_UNITS); i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Out-of-range indices read as empty.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < int'(MAX_UNITS)) rd_data = mem_q[rd_idx];
    end

endmodule

// File: rtl/ch_msg_decoder.sv
// UART message decoder: collects unit codes from IFM frames during the IFM
// phase, then reports end points carried by PBM frames.
module ch_msg_decoder
    import ch_msg_decoder_pkg::*;
#(
    parameter int unsigned MAX_UNITS = 4,
    parameter int unsigned CODE_W    = 2,
    parameter int unsigned PHASE_DLY = 500000000,
    parameter int unsigned BYTE_TMO  = 5000000,
    localparam int unsigned IdxW     = $clog2(MAX_UNITS),
    localparam int unsigned CntW     = IdxW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [IdxW-1:0]   rd_idx,
    output logic [CODE_W-1:0] rd_code,
    output logic [CntW-1:0]   unit_count,
    output logic              ifm_done,
    output logic              pbm_valid,
    output logic [5:0]        end_point,
    output logic              frame_err,
    output logic              overflow
);

    localparam int unsigned PhaseW = $clog2(PHASE_DLY + 1);
    localparam int unsigned TmoW   = $clog2(BYTE_TMO + 1);

    state_e            state_q, state_d;
    unit_code_e        unit_q, unit_d;
    logic [5:0]        node_q, node_d;
    logic [5:0]        end_point_q, end_point_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic [TmoW-1:0]   tmo_cnt_q;
    logic              ifm_done_q, overflow_q, overflow_d, frame_err_q, frame_err_d;
    logic              tbl_we, ok, idle_like, start_ok, timeout, full;
    state_e            nxt, start_state;
    logic [7:0]        b;

    assign b           = to_upper(rx_data);
    assign full        = (count_q == CntW'(MAX_UNITS));
    assign start_ok    = (!ifm_done_q && b == ChI) || (ifm_done_q && b == ChP);
    assign start_state = (b == ChI) ? StIfmHdr0 : StPbmHdr0;
    // Frame-complete states last one cycle and accept a new start byte like IDLE.
    assign idle_like   = (state_q == StIdle) || (state_q == StIfmTail2) ||
                         (state_q == StPbmTail1);
    assign timeout     = !idle_like && !rx_valid && (tmo_cnt_q == TmoW'(BYTE_TMO - 1));
    assign phase_cnt_d = (phase_cnt_q == PhaseW'(PHASE_DLY)) ? phase_cnt_q
                                                             : phase_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        node_d      = node_q;
        end_point_d = end_point_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        frame_err_d = 1'b0;
        tbl_we      = 1'b0;
        ok          = 1'b0;
        nxt         = StIdle;

        unique case (state_q)
            StIfmHdr0:  begin ok = (b == ChF);    nxt = StIfmHdr1;  end
            StIfmHdr1:  begin ok = (b == ChM);    nxt = StIfmHdr2;  end
            StIfmHdr2:  begin ok = (b == ChDash); nxt = StIfmHdr3;  end
            StIfmHdr3:  begin ok = (b == ChE || b == ChC || b == ChR); nxt = StIfmUnit; end
            StIfmUnit:  begin ok = (b == ChU);    nxt = StIfmTail0; end
            StIfmTail0: begin ok = (b == ChDash); nxt = StIfmTail1; end
            StIfmTail1: begin ok = (b == ChHash); nxt = StIfmTail2; end
            StPbmHdr0:  begin ok = (b == ChB);    nxt = StPbmHdr1;  end
            StPbmHdr1:  begin ok = (b == ChM);    nxt = StPbmHdr2;  end
            StPbmHdr2:  begin ok = (b == ChDash); nxt = StPbmHdr3;  end
            StPbmHdr3:  begin ok = (b == ChS);    nxt = StPbmBody0; end
            StPbmBody0: begin ok = (b == ChU);    nxt = StPbmBody1; end
            StPbmBody1: begin ok = (b == ChDash); nxt = StPbmBody2; end
            StPbmBody2: begin ok = (b == ChB);    nxt = StPbmBody3; end
            StPbmBody3: begin ok = (b >= 8'h31 && b <= 8'h34); nxt = StPbmBody4; end
            StPbmBody4: begin ok = (b == ChDash); nxt = StPbmTail0; end
            StPbmTail0: begin ok = (b == ChHash); nxt = StPbmTail1; end
            default:    begin ok = 1'b0;          nxt = StIdle;     end
        endcase

        if (idle_like) begin
            state_d = (rx_valid && start_ok) ? start_state : StIdle;
        end else if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
        end else if (rx_valid) begin
            if (ok) begin
                state_d = nxt;
                if (state_q == StIfmHdr3)  unit_d = letter_to_unit(b);
                if (state_q == StPbmBody3) node_d = digit_to_node(b);
                if (state_q == StPbmTail0) end_point_d = node_q;
                if (state_q == StIfmTail1) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        tbl_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
            end else begin
                frame_err_d = 1'b1;
                state_d     = start_ok ? start_state : StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            unit_q      <= UnitEmpty;
            node_q      <= '0;
            end_point_q <= '0;
            count_q     <= '0;
            phase_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            ifm_done_q  <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            unit_q      <= unit_d;
            node_q      <= node_d;
            end_point_q <= end_point_d;
            count_q     <= count_d;
            phase_cnt_q <= phase_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            ifm_done_q  <= ifm_done_q || (phase_cnt_d == PhaseW'(PHASE_DLY)) ||
                           (count_d == CntW'(MAX_UNITS));
            if (rx_valid) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != TmoW'(BYTE_TMO)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    unit_table #(
        .MAX_UNITS (MAX_UNITS),
        .CODE_W    (CODE_W),
        .IDX_W     (IdxW)
    ) u_unit_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (tbl_we),
        .wr_idx  (count_q[IdxW-1:0]),
        .wr_data (CODE_W'(unit_q)),
        .rd_idx  (rd_idx),
        .rd_data (rd_code)
    );

    assign unit_count = count_q;
    assign ifm_done   = ifm_done_q;
    assign pbm_valid  = (state_q == StPbmTail1);
    assign end_point  = end_point_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ch_msg_decoder.sv
// Self-checking bench for ch_msg_decoder with a short phase delay and byte timeout.
module tb_ch_msg_decoder;

    localparam int unsigned MaxUnits = 4;
    localparam int unsigned PhaseDly = 100;
    localparam int unsigned ByteTmo  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [1:0] rd_idx = 2'd0;
    logic [1:0] rd_code;
    logic [2:0] unit_count;
    logic       ifm_done, pbm_valid, frame_err, overflow;
    logic [5:0] end_point;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;
    int err_base;
    logic [5:0] exp_q [$];

    ch_msg_decoder #(
        .MAX_UNITS (MaxUnits),
        .CODE_W    (2),
        .PHASE_DLY (PhaseDly),
        .BYTE_TMO  (ByteTmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rd_idx     (rd_idx),
        .rd_code    (rd_code),
        .unit_count (unit_count),
        .ifm_done   (ifm_done),
        .pbm_valid  (pbm_valid),
        .end_point  (end_point),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every accepted PBM frame must match the oldest pending end point.
    always @(negedge clk) begin
        if (rst_n && pbm_valid) begin
            if (exp_q.size() == 0) check("pbm_unexpected", 32'd1, 32'd0);
            else check("pbm_end_point", 32'(end_point), 32'(exp_q.pop_front()));
        end
        if (frame_err) err_seen++;
    end

    task automatic send_byte(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_code(input string tag, input logic [1:0] idx, input logic [1:0] exp);
        rd_idx = idx;
        #1;
        check(tag, 32'(rd_code), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #3;
        check("rst_unit_count", 32'(unit_count), 0);
        check("rst_ifm_done", 32'(ifm_done), 0);
        check("rst_end_point", 32'(end_point), 0);
        check("rst_rd_code", 32'(rd_code), 0);
        do_reset();

        // Two IFM frames, mixed case; same-slot write shows old value first
        err_base = err_seen;
        rd_idx = 2'd1;
        send_str("IFM-EU-#ifm-cu-");
        rx_valid = 1'b1;
        rx_data  = "#";
        #2;
        check("same_cycle_old", 32'(rd_code), 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("next_cycle_new", 32'(rd_code), 2);
        check_code("t1_code0", 2'd0, 2'd1);
        check_code("t1_code1", 2'd1, 2'd2);
        check("t1_count", 32'(unit_count), 2);
        check("t1_no_err", 32'(err_seen - err_base), 0);

        // Fill the table; a fifth frame is ignored after the phase closes
        do_reset();
        err_base = err_seen;
        send_str("IFM-RU-#IFM-EU-#IFM-CU-#");
        check("t2_not_done", 32'(ifm_done), 0);
        send_str("IFM-RU-#");
        check("t2_done", 32'(ifm_done), 1);
        check("t2_count4", 32'(unit_count), 4);
        send_str("IFM-EU-#");
        repeat (2) @(posedge clk);
        #1;
        check("t2_overflow", 32'(overflow), 0);
        check("t2_count_hold", 32'(unit_count), 4);
        check_code("t2_code3", 2'd3, 2'd3);
        check_code("t2_code1", 2'd1, 2'd1);
        check("t2_no_err", 32'(err_seen - err_base), 0);

        // Mismatch at 'X' with resync-free recovery
        do_reset();
        err_base = err_seen;
        send_str("IFXIFM-RU-#");
        repeat (2) @(posedge clk);
        #1;
        check("t3_one_err", 32'(err_seen - err_base), 1);
        check_code("t3_code0", 2'd0, 2'd3);
        check("t3_count", 32'(unit_count), 1);

        // Byte timeout mid-frame
        do_reset();
        err_base = err_seen;
        send_str("IFM-E");
        repeat (ByteTmo - 1) @(posedge clk);
        #1;
        check("t4_no_err_early", 32'(frame_err), 0);
        @(posedge clk);
        #1;
        check("t4_err_pulse", 32'(frame_err), 1);
        check("t4_count", 32'(unit_count), 0);
        send_str("IFM-CU-#");
        repeat (2) @(posedge clk);
        #1;
        check("t4_one_err", 32'(err_seen - err_base), 1);
        check_code("t4_code0", 2'd0, 2'd2);

        // Phase closes on time, then PBM frames
        do_reset();
        err_base = err_seen;
        repeat (PhaseDly - 1) @(posedge clk);
        #1;
        check("t5_done_early", 32'(ifm_done), 0);
        @(posedge clk);
        #1;
        check("t5_done", 32'(ifm_done), 1);
        exp_q.push_back(6'd23);
        send_str("PBM-SU-B3-#");
        check("t5_valid", 32'(pbm_valid), 1);
        check("t5_ep", 32'(end_point), 23);
        @(posedge clk);
        #1;
        check("t5_valid_drop", 32'(pbm_valid), 0);
        check("t5_ep_hold", 32'(end_point), 23);
        exp_q.push_back(6'd22);
        exp_q.push_back(6'd11);
        send_str("pbm-su-b1-#PBM-SU-B4-#");
        @(posedge clk);
        #1;
        check("t5_ep_last", 32'(end_point), 11);

        // Reset mid-frame clears everything without an error pulse
        send_str("PBM-SU-B");
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ep", 32'(end_point), 0);
        check("t6_rst_done", 32'(ifm_done), 0);
        check("t6_rst_valid", 32'(pbm_valid), 0);
        check("t6_rst_err", 32'(frame_err), 0);
        check("t6_rst_ovf", 32'(overflow), 0);
        check("t6_rst_count", 32'(unit_count), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (PhaseDly + 1) @(posedge clk);
        #1;
        exp_q.push_back(6'd10);
        send_str("PBM-SU-B2-#");
        @(posedge clk);
        #1;
        check("t6_ep", 32'(end_point), 10);
        check("t6_no_err", 32'(err_seen - err_base), 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ch_msg_decoder.md
CH_MSG_DECODER -- requirements
Module: ch_msg_decoder

Interface
REQ-001 Parameter MAX_UNITS, default 4: number of unit-table slots, range 2..16.
REQ-002 Parameter CODE_W, default 2: width of one unit code.
REQ-003 Parameter PHASE_DLY, default 500000000: clk cycles before the IFM phase closes on time.
REQ-004 Parameter BYTE_TMO, default 5000000: maximum idle clk cycles allowed between bytes of one frame.
REQ-005 clk  in  1  system clock; one clock; all logic rises on posedge clk.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
REQ-008 rx_data  in  8  received UART byte.
REQ-009 rd_idx  in  clog2(MAX_UNITS)  unit-table read index.
REQ-010 rd_code  out  CODE_W  combinational table[rd_idx]: 0 empty, 1 E, 2 C, 3 R.
REQ-011 unit_count  out  clog2(MAX_UNITS)+1  number of filled slots.
REQ-012 ifm_done  out  1  level; the IFM phase has closed.
REQ-013 pbm_valid  out  1  one-cycle pulse; a PBM frame has been accepted.
REQ-014 end_point  out  6  node ID of the last accepted PBM frame.
REQ-015 frame_err  out  1  one-cycle pulse on a malformed or timed-out frame.
REQ-016 overflow  out  1  sticky; an IFM frame arrived while the table was full.

Function
REQ-017 Letters SHALL match case-insensitively; '-' is 0x2D and '#' is 0x23.
REQ-018 The IFM frame SHALL be the byte sequence I F M - u U - #, where u is one of E, C or R.
REQ-019 The PBM frame SHALL be the byte sequence P B M - S U - B d - #, where d is 1..4.
REQ-020 The parser FSM SHALL have these states: IDLE, IFM_HDR(0..3), IFM_UNIT, IFM_TAIL(0..2), PBM_HDR(0..3), PBM_BODY(0..4), PBM_TAIL(0..1).
REQ-021 The FSM SHALL advance exactly one position per rx_valid; with no rx_valid, it holds.
REQ-022 In IDLE, 'I' SHALL be accepted only while ifm_done=0, and 'P' only while ifm_done=1; any other byte SHALL be ignored without an error.
REQ-023 Each unit code SHALL be latched at IFM_UNIT and written to table[unit_count] only on the final '#', and unit_count SHALL then increment in the same cycle.
REQ-024 On the final '#' of an IFM frame with unit_count==MAX_UNITS, the table SHALL NOT be written and overflow SHALL be set to 1.
REQ-025 The digit d SHALL map to end_point as follows: 1->22, 2->10, 3->23, 4->11.
REQ-026 end_point SHALL update, and pbm_valid SHALL pulse, in the cycle after the final '#' is received; end_point holds that value until the next accepted PBM frame.
REQ-027 A mismatch at any non-IDLE position SHALL pulse frame_err, discard the partial frame and return to IDLE; if the offending byte is a valid start byte for the current phase, the FSM goes to the state after IDLE for that byte instead (resync).
REQ-028 A byte counter SHALL reset on every rx_valid; if it reaches BYTE_TMO while not in IDLE, the FSM SHALL pulse frame_err and return to IDLE.
REQ-029 ifm_done SHALL be set once the phase counter reaches PHASE_DLY, or once unit_count reaches MAX_UNITS, whichever comes first.
REQ-030 ifm_done SHALL stay 1 until reset, and the phase counter SHALL saturate.
REQ-031 If ifm_done rises mid-IFM-frame, that frame SHALL still complete normally.
REQ-032 If a write and rd_idx target the same slot in the same cycle, rd_code SHALL show the old value in that cycle and the new value in the next.
REQ-033 rd_idx >= MAX_UNITS SHALL return 0.

Reset
REQ-034 rst_n low SHALL immediately clear: FSM to IDLE; all table slots, unit_count, both counters, ifm_done, overflow, pbm_valid and frame_err to 0; end_point to 0.
REQ-035 Reset asserted mid-frame SHALL discard the frame with no frame_err pulse.

Structure
REQ-036 A shared package SHALL hold the ASCII byte constants, the unit-code enumeration (EMPTY/E/C/R), the FSM state encoding and the digit-to-node table.
REQ-037 A single sub-module, unit_table, SHALL be used: a MAX_UNITS x CODE_W register file with one write port and one combinational read port.

Verification
REQ-038 Send "IFM-EU-#" then "ifm-cu-#" -> rd_code[0]=1, rd_code[1]=2, unit_count=2, no frame_err.
REQ-039 Send four IFM frames (R,E,C,R) -> ifm_done=1 after the 4th '#'; a 5th IFM frame -> ignored in IDLE, overflow stays 0.
REQ-040 With PHASE_DLY=100 and no input, then "PBM-SU-B3-#" -> ifm_done rises at cycle 100; end_point=23 and pbm_valid=1 for exactly one cycle.
REQ-041 Send "IFX" then "IFM-RU-#" -> one frame_err at 'X'; the frame then parses and rd_code[0]=3.
REQ-042 Send "IFM-E" then idle for BYTE_TMO cycles -> one frame_err, FSM in IDLE, unit_count unchanged.
REQ-043 Assert rst_n low after "PBM-SU-B" -> all outputs 0 and no frame_err; then "PBM-SU-B2-#" after the IFM phase closes -> end_point=10.
